oc8051_fetch_queue: RTL and testbench

- Instruction prefetch stage between the combinational code ROM and the oc8051 core decode.
- Drives the ROM word address and captures 4 code bytes per fill into a circular byte queue.
- Presents a 3-byte instruction window (max 8051 instruction length) plus the window's PC to the core.
- Core retires 0-3 bytes per cycle; a jump/branch flushes the queue and redirects fetch.

---
 rtl/oc8051_fetch_queue_if.sv | 22 ++
 rtl/oc8051_fetch_queue.sv | 110 +++++++++++
 tb/tb_oc8051_fetch_queue.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/oc8051_fetch_queue_if.sv
// Fetch-queue bus: ROM address/data, redirect and retire inputs, and the
// 3-byte instruction window handed to the core.
interface oc8051_fetch_queue_if;
  logic [15:0] cxrom_addr;
  logic [31:0] cxrom_data_in;
  logic        pc_load;
  logic [15:0] pc_new;
  logic [1:0]  consume;
  logic [23:0] win_data;
  logic [15:0] win_pc;
  logic [1:0]  win_cnt;

  modport slave (
    output cxrom_addr, win_data, win_pc, win_cnt,
    input  cxrom_data_in, pc_load, pc_new, consume
  );

  modport master (
    input  cxrom_addr, win_data, win_pc, win_cnt,
    output cxrom_data_in, pc_load, pc_new, consume
  );
endinterface

// File: rtl/oc8051_fetch_queue.sv
// oc8051 instruction prefetch: 4-byte ROM fills into a circular byte queue,
// 3-byte window to decode. Define OC8051_FETCH_STATS_EN for fill/flush counters.
module oc8051_fetch_queue #(
  parameter int          QDEPTH   = 8,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                   clk,
  input  logic                   rst,
  oc8051_fetch_queue_if.slave    bus
`ifdef OC8051_FETCH_STATS_EN
  ,
  output logic [31:0]            fill_cnt,
  output logic [15:0]            flush_cnt
`endif
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  logic [15:0]   fetch_addr;
  logic [15:0]   head_pc;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [7:0]    q [QDEPTH];

  logic [1:0]    win_cnt_c;
  logic [1:0]    cons_eff;
  logic          fill;
  logic [7:0]    win_byte [3];

  function automatic logic [1:0] clamp3(input logic [CW-1:0] n);
    return (n >= CW'(3)) ? 2'd3 : n[1:0];
  endfunction

  function automatic logic [1:0] min2(input logic [1:0] a, input logic [1:0] b);
    return (a < b) ? a : b;
  endfunction

`ifdef OC8051_FETCH_STATS_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction
`endif

  // Fill is judged on pre-consume occupancy so a fill can never overflow.
  always_comb begin
    win_cnt_c = clamp3(count);
    cons_eff  = min2(bus.consume, win_cnt_c);
    fill      = (count <= CW'(QDEPTH - 4));
    for (int i = 0; i < 3; i++) begin
      win_byte[i] = (2'(i) < win_cnt_c) ? q[rd_ptr + PW'(i)] : 8'h00;
    end
  end

  assign bus.cxrom_addr = fetch_addr;
  assign bus.win_pc     = head_pc;
  assign bus.win_cnt    = win_cnt_c;
  assign bus.win_data   = {win_byte[2], win_byte[1], win_byte[0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_addr <= RESET_PC;
      head_pc    <= RESET_PC;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
    end else if (bus.pc_load) begin
      fetch_addr <= bus.pc_new;
      head_pc    <= bus.pc_new;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
    end else begin
      if (fill) begin
        wr_ptr     <= wr_ptr + PW'(4);
        fetch_addr <= fetch_addr + 16'd4;
      end
      rd_ptr  <= rd_ptr + PW'(cons_eff);
      head_pc <= head_pc + 16'(cons_eff);
      count   <= count + (fill ? CW'(4) : CW'(0)) - CW'(cons_eff);
    end
  end

  // Queue storage carries data only; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (fill && !bus.pc_load) begin
      for (int k = 0; k < 4; k++) begin
        q[wr_ptr + PW'(k)] <= bus.cxrom_data_in[8*k +: 8];
      end
    end
  end

`ifdef OC8051_FETCH_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_cnt  <= '0;
      flush_cnt <= '0;
    end else begin
      if (bus.pc_load) flush_cnt <= sat_inc16(flush_cnt);
      else if (fill)   fill_cnt  <= sat_inc32(fill_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_oc8051_fetch_queue.sv
// Scoreboard bench for oc8051_fetch_queue: byte-queue reference model,
// directed redirect/wrap/reset cases plus randomized redirect/consume traffic.
module tb_oc8051_fetch_queue;

  localparam int          QD  = 8;
  localparam logic [15:0] RPC = 16'h0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  oc8051_fetch_queue_if bus ();

`ifdef OC8051_FETCH_STATS_EN
  logic [31:0] fill_cnt;
  logic [15:0] flush_cnt;
`endif

  oc8051_fetch_queue #(.QDEPTH(QD), .RESET_PC(RPC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef OC8051_FETCH_STATS_EN
    ,
    .fill_cnt  (fill_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  // Code ROM: byte(a) = a[7:0], four consecutive bytes, combinational.
  function automatic logic [7:0] rom_byte(input logic [15:0] a);
    return a[7:0];
  endfunction

  function automatic logic [31:0] rom4(input logic [15:0] a);
    return {rom_byte(a + 16'd3), rom_byte(a + 16'd2), rom_byte(a + 16'd1), rom_byte(a)};
  endfunction

  assign bus.cxrom_data_in = rom4(bus.cxrom_addr);

  typedef struct {
    logic [15:0] addr;
    logic [15:0] pc;
    logic [1:0]  cnt;
    logic [23:0] data;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  // Reference model: an ordered list of the code bytes currently buffered.
  logic [7:0]  mq[$];
  logic [15:0] m_fetch;
  logic [15:0] m_head;

  function automatic exp_t model_outputs();
    exp_t e;
    int   wc;
    logic [7:0] b [3];
    wc = (mq.size() < 3) ? mq.size() : 3;
    for (int i = 0; i < 3; i++) b[i] = (i < wc) ? mq[i] : 8'h00;
    e.addr = m_fetch;
    e.pc   = m_head;
    e.cnt  = 2'(wc);
    e.data = {b[2], b[1], b[0]};
    return e;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_fetch = RPC;
    m_head  = RPC;
  endtask

  task automatic model_edge(input logic pl, input logic [15:0] pn, input logic [1:0] cn);
    int  wc;
    int  ce;
    bit  do_fill;
    if (pl) begin
      mq.delete();
      m_fetch = pn;
      m_head  = pn;
    end else begin
      wc      = (mq.size() < 3) ? mq.size() : 3;
      ce      = (int'(cn) < wc) ? int'(cn) : wc;
      do_fill = (QD - mq.size()) >= 4;
      for (int i = 0; i < ce; i++) void'(mq.pop_front());
      m_head = m_head + 16'(ce);
      if (do_fill) begin
        for (int k = 0; k < 4; k++) mq.push_back(rom_byte(m_fetch + 16'(k)));
        m_fetch = m_fetch + 16'd4;
      end
    end
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Called at posedge+1: drive inputs for this cycle, queue what the DUT
  // must show during it, then advance the model across the next edge.
  task automatic step(input logic pl, input logic [15:0] pn, input logic [1:0] cn);
    bus.pc_load = pl;
    bus.pc_new  = pn;
    bus.consume = cn;
    sb.push_back(model_outputs());
    @(posedge clk);
    model_edge(pl, pn, cn);
    #1;
  endtask

  // Monitor: compare every cycle the stimulus has an expectation pending.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cmp("sb_cxrom_addr", 32'(bus.cxrom_addr), 32'(e.addr));
        cmp("sb_win_pc",     32'(bus.win_pc),     32'(e.pc));
        cmp("sb_win_cnt",    32'(bus.win_cnt),    32'(e.cnt));
        cmp("sb_win_data",   32'(bus.win_data),   32'(e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       pl;
    logic [1:0] cn;
    rst         = 1'b1;
    bus.pc_load = 1'b0;
    bus.pc_new  = 16'h0000;
    bus.consume = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    cmp("reset_addr", 32'(bus.cxrom_addr), 32'(RPC));
    cmp("reset_cnt",  32'(bus.win_cnt),    32'd0);
    cmp("reset_data", 32'(bus.win_data),   32'd0);
    rst = 1'b0;
    model_reset();

    // First fill after reset, then hold with no consume until full.
    step(1'b0, 16'h0, 2'd0);
    cmp("first_win_cnt",  32'(bus.win_cnt),    32'd3);
    cmp("first_win_data", 32'(bus.win_data),   32'h020100);
    cmp("first_win_pc",   32'(bus.win_pc),     32'h0000);
    cmp("first_addr",     32'(bus.cxrom_addr), 32'h0004);
    repeat (3) step(1'b0, 16'h0, 2'd0);
    cmp("full_addr_hold", 32'(bus.cxrom_addr), 32'h0008);
    cmp("full_win_data",  32'(bus.win_data),   32'h020100);

    repeat (5) step(1'b0, 16'h0, 2'd3);

    // Redirect with a simultaneous consume, then consume while empty.
    step(1'b1, 16'h1234, 2'd2);
    cmp("redir_cnt",  32'(bus.win_cnt),    32'd0);
    cmp("redir_pc",   32'(bus.win_pc),     32'h1234);
    cmp("redir_addr", 32'(bus.cxrom_addr), 32'h1234);
    step(1'b0, 16'h0, 2'd3);
    cmp("empty_cons_pc",   32'(bus.win_pc),   32'h1234);
    cmp("empty_cons_data", 32'(bus.win_data), 32'h363534);
    cmp("empty_cons_cnt",  32'(bus.win_cnt),  32'd3);

    // Address wrap across 16'hFFFF.
    step(1'b1, 16'hFFFE, 2'd0);
    cmp("wrap_addr0", 32'(bus.cxrom_addr), 32'hFFFE);
    step(1'b0, 16'h0, 2'd0);
    cmp("wrap_data",  32'(bus.win_data),   32'h00FFFE);
    cmp("wrap_pc",    32'(bus.win_pc),     32'hFFFE);
    cmp("wrap_addr1", 32'(bus.cxrom_addr), 32'h0002);
    step(1'b0, 16'h0, 2'd3);
    cmp("wrap_pc2",   32'(bus.win_pc),     32'h0001);
    cmp("wrap_addr2", 32'(bus.cxrom_addr), 32'h0006);

    for (int n = 0; n < 400; n++) begin
      pl = ($urandom_range(0, 15) == 0);
      cn = 2'($urandom_range(0, 3));
      step(pl, 16'($urandom), cn);
    end

    // Asynchronous reset mid-cycle: outputs must clear before any edge.
    #1 rst = 1'b1;
    #1;
    cmp("async_rst_addr", 32'(bus.cxrom_addr), 32'(RPC));
    cmp("async_rst_pc",   32'(bus.win_pc),     32'(RPC));
    cmp("async_rst_cnt",  32'(bus.win_cnt),    32'd0);
    cmp("async_rst_data", 32'(bus.win_data),   32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();

    for (int n = 0; n < 200; n++) begin
      pl = ($urandom_range(0, 19) == 0);
      cn = 2'($urandom_range(0, 3));
      step(pl, 16'($urandom), cn);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
